// File: rtl/cdc_hs_src.sv
// rtl/cdc_hs_src.sv - source side of a 4-phase req/ack clock-domain-crossing handshake
//
// Optional feature macro: CDC_HS_SRC_TIMEOUT_EN
//   defined   -> per-phase watchdog; a stuck handshake is abandoned and
//                timeout_err latches until reset
//   undefined -> no watchdog logic, timeout_err tied low, FSM waits forever
module cdc_hs_src #(
  parameter int DataWidth     = 32,
  parameter int SyncStage     = 2,
  parameter int TimeoutCycles = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [DataWidth-1:0] s_data,
  output logic                 cdc_req,
  output logic [DataWidth-1:0] cdc_data,
  input  logic                 cdc_ack,
  output logic                 busy,
  output logic                 timeout_err
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_ACK_HI = 2'd1,
    WAIT_ACK_LO = 2'd2
  } state_t;

  state_t               state;
  state_t               state_next;
  logic                 req_next;
  logic                 load_data;
  logic [SyncStage-1:0] ack_sync;
  logic                 ack_s;
  logic                 wd_expire;

  // cdc_ack is asynchronous: only this chain may look at it.
  always_ff @(posedge clk) begin
    if (reset) begin
      ack_sync <= '0;
    end else begin
      ack_sync <= {ack_sync[SyncStage-2:0], cdc_ack};
    end
  end

  assign ack_s   = ack_sync[SyncStage-1];
  assign s_ready = (state == IDLE);
  assign busy    = (state != IDLE);

`ifdef CDC_HS_SRC_TIMEOUT_EN
  localparam int CntW = $clog2(TimeoutCycles);

  logic [CntW-1:0] wd_cnt;
  logic            wd_fire;

  assign wd_expire = (state != IDLE) && (wd_cnt == CntW'(TimeoutCycles - 1));

  // The watchdog only counts as a failure when the ack did not arrive on
  // the very same cycle the limit was reached.
  assign wd_fire = wd_expire &&
                   (((state == WAIT_ACK_HI) && !ack_s) ||
                    ((state == WAIT_ACK_LO) &&  ack_s));

  // Per-phase cycle counter: restarts on every state change.
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt <= '0;
    end else if (state_next != state) begin
      wd_cnt <= '0;
    end else if (state != IDLE) begin
      wd_cnt <= wd_cnt + 1'b1;
    end else begin
      wd_cnt <= '0;
    end
  end

  // Sticky timeout flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      timeout_err <= 1'b0;
    end else if (wd_fire) begin
      timeout_err <= 1'b1;
    end
  end
`else
  assign wd_expire   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Next-state, request and capture decisions.
  always_comb begin
    state_next = state;
    req_next   = cdc_req;
    load_data  = 1'b0;
    case (state)
      IDLE: begin
        if (s_valid) begin
          load_data  = 1'b1;
          req_next   = 1'b1;
          state_next = WAIT_ACK_HI;
        end
      end
      WAIT_ACK_HI: begin
        if (ack_s || wd_expire) begin
          req_next   = 1'b0;
          state_next = WAIT_ACK_LO;
        end
      end
      WAIT_ACK_LO: begin
        if (!ack_s || wd_expire) begin
          state_next = IDLE;
        end
      end
      default: begin
        req_next   = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  // State, request and held word; cdc_req and cdc_data come straight from flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cdc_req  <= 1'b0;
      cdc_data <= '0;
    end else begin
      state   <= state_next;
      cdc_req <= req_next;
      if (load_data) begin
        cdc_data <= s_data;
      end
    end
  end

endmodule
